// File: rtl/xif_host_offload.sv
// xif_host_offload: host-CPU-side initiator for the CORE-V-XIF issue, commit and
// result channels. One instruction is in flight on the issue channel at a time;
// up to MAX_OUTSTANDING accepted instructions may await their results.
// Optional feature macro: XIF_HOST_PROTOCOL_CHECK_EN enables the sticky
// protocol_err checker. Without it protocol_err is tied low, but results for
// non-pending IDs or unexpected writebacks are still kept out of the register file.
module xif_host_offload #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned X_NUM_RS        = 3,
    parameter int unsigned X_ID_WIDTH      = 4,
    parameter int unsigned X_RFR_WIDTH     = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    // core side
    input  logic                                    off_valid,
    output logic                                    off_ready,
    input  logic [31:0]                             off_instr,
    input  logic [X_NUM_RS*X_RFR_WIDTH-1:0]         off_rs,
    input  logic                                    off_kill,
    output logic                                    off_done,
    output logic                                    off_accepted,
    // XIF issue channel
    output logic                                    issue_valid,
    input  logic                                    issue_ready,
    output logic [31:0]                             issue_instr,
    output logic [X_ID_WIDTH-1:0]                   issue_id,
    output logic [X_NUM_RS*X_RFR_WIDTH-1:0]         issue_rs,
    output logic [X_NUM_RS-1:0]                     issue_rs_valid,
    output logic [1:0]                              issue_mode,
    input  logic                                    issue_accept,
    input  logic                                    issue_writeback,
    // XIF commit channel
    output logic                                    commit_valid,
    output logic [X_ID_WIDTH-1:0]                   commit_id,
    output logic                                    commit_kill,
    // XIF result channel
    input  logic                                    result_valid,
    output logic                                    result_ready,
    input  logic [X_ID_WIDTH-1:0]                   result_id,
    input  logic [XLEN-1:0]                         result_data,
    input  logic [4:0]                              result_rd,
    input  logic                                    result_we,
    input  logic                                    result_exc,
    input  logic [5:0]                              result_exccode,
    // integer register file write port
    output logic                                    rf_we,
    output logic [4:0]                              rf_waddr,
    output logic [XLEN-1:0]                         rf_wdata,
    // status
    output logic                                    exc_valid,
    output logic [5:0]                              exc_code,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]    outstanding,
    output logic                                    protocol_err
);

    localparam int unsigned NUM_IDS = 2 ** X_ID_WIDTH;
    localparam int unsigned RS_W    = X_NUM_RS * X_RFR_WIDTH;
    localparam int unsigned OCNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OCNT_W-1:0] MAX_OUT_C = OCNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Number of set bits in the pending vector.
    function automatic logic [OCNT_W-1:0] popcount_ids(input logic [NUM_IDS-1:0] v);
        logic [OCNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            cnt = cnt + OCNT_W'(v[i]);
        end
        return cnt;
    endfunction

    // issue-side state
    state_e                  state_q, state_d;
    logic [31:0]             instr_q, instr_d;
    logic [RS_W-1:0]         rs_q, rs_d;
    logic                    kill_q, kill_d;
    logic                    accept_q, accept_d;
    logic [X_ID_WIDTH-1:0]   id_q, id_d;
    logic [X_ID_WIDTH-1:0]   next_id_q, next_id_d;

    // ID tracking
    logic [NUM_IDS-1:0]      pending_q, pending_d;
    logic [NUM_IDS-1:0]      wb_exp_q, wb_exp_d;
    logic [OCNT_W-1:0]       outstanding_q, outstanding_d;
    logic [NUM_IDS-1:0]      set_mask_s;
    logic [NUM_IDS-1:0]      kill_clr_mask_s;
    logic [NUM_IDS-1:0]      res_clr_mask_s;

    // result-side registered outputs
    logic                    rf_we_q, rf_we_d;
    logic [4:0]              rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]         rf_wdata_q, rf_wdata_d;
    logic                    exc_valid_q, exc_valid_d;
    logic [5:0]              exc_code_q, exc_code_d;

    // combinational helpers
    logic                    off_ready_s;
    logic                    issue_valid_s;
    logic                    commit_valid_s;
    logic                    off_done_s;
    logic                    result_ready_s;
    logic                    result_hs_s;
    logic                    res_pending_s;
    logic                    res_wb_s;

    // Channel handshake qualifiers; everything is forced quiet while rst is high
    // so an abort takes effect in the cycle it is requested.
    always_comb begin
        issue_valid_s  = (state_q == ST_ISSUE) && !rst;
        off_done_s     = (state_q == ST_COMMIT) && !rst;
        commit_valid_s = off_done_s && accept_q;
        result_ready_s = !rst;
        result_hs_s    = result_valid && result_ready_s;
        res_pending_s  = pending_q[result_id];
        res_wb_s       = wb_exp_q[result_id];
    end

    // Issue FSM: next state, latched transaction fields and pending set/kill masks.
    always_comb begin
        state_d         = state_q;
        instr_d         = instr_q;
        rs_d            = rs_q;
        kill_d          = kill_q;
        accept_d        = accept_q;
        id_d            = id_q;
        next_id_d       = next_id_q;
        wb_exp_d        = wb_exp_q;
        set_mask_s      = '0;
        kill_clr_mask_s = '0;
        off_ready_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A free ID and room below the outstanding limit are both required.
                if (!rst && !pending_q[next_id_q] && (outstanding_q < MAX_OUT_C)) begin
                    off_ready_s = 1'b1;
                end else begin
                    off_ready_s = 1'b0;
                end
                if (off_valid && off_ready_s) begin
                    instr_d = off_instr;
                    rs_d    = off_rs;
                    kill_d  = off_kill;
                    id_d    = next_id_q;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (issue_ready) begin
                    accept_d = issue_accept;
                    if (issue_accept) begin
                        set_mask_s[id_q] = 1'b1;
                        wb_exp_d[id_q]   = issue_writeback;
                        next_id_d        = next_id_q + X_ID_WIDTH'(1'b1);
                    end else begin
                        next_id_d        = next_id_q;
                    end
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_COMMIT: begin
                // A killed instruction never returns a result, so free its ID now.
                if (accept_q && kill_q) begin
                    kill_clr_mask_s[id_q] = 1'b1;
                end else begin
                    kill_clr_mask_s = '0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Result channel: free the ID and prepare the gated register-file write.
    always_comb begin
        res_clr_mask_s = '0;
        rf_we_d        = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        exc_valid_d    = 1'b0;
        exc_code_d     = exc_code_q;
        if (result_hs_s) begin
            res_clr_mask_s[result_id] = 1'b1;
            if (result_exc) begin
                exc_valid_d = 1'b1;
                exc_code_d  = result_exccode;
            end else if (result_we && res_pending_s && res_wb_s && (result_rd != 5'd0)) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = result_rd;
                rf_wdata_d = result_data;
            end else begin
                rf_we_d    = 1'b0;
            end
        end else begin
            res_clr_mask_s = '0;
        end
    end

    // Pending vector merge: all set/clear events on distinct IDs apply together.
    always_comb begin
        pending_d     = (pending_q & ~(res_clr_mask_s | kill_clr_mask_s)) | set_mask_s;
        outstanding_d = popcount_ids(pending_d);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            instr_q       <= 32'd0;
            rs_q          <= '0;
            kill_q        <= 1'b0;
            accept_q      <= 1'b0;
            id_q          <= '0;
            next_id_q     <= '0;
            pending_q     <= '0;
            wb_exp_q      <= '0;
            outstanding_q <= '0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= 5'd0;
            rf_wdata_q    <= '0;
            exc_valid_q   <= 1'b0;
            exc_code_q    <= 6'd0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            rs_q          <= rs_d;
            kill_q        <= kill_d;
            accept_q      <= accept_d;
            id_q          <= id_d;
            next_id_q     <= next_id_d;
            pending_q     <= pending_d;
            wb_exp_q      <= wb_exp_d;
            outstanding_q <= outstanding_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            exc_valid_q   <= exc_valid_d;
            exc_code_q    <= exc_code_d;
        end
    end

`ifdef XIF_HOST_PROTOCOL_CHECK_EN
    logic protocol_err_q, protocol_err_d;

    // Sticky protocol checker: bad result IDs, unexpected writebacks, stray issue_ready.
    always_comb begin
        protocol_err_d = protocol_err_q;
        if (result_hs_s && (!res_pending_s || (result_we && !res_wb_s))) begin
            protocol_err_d = 1'b1;
        end else if (issue_ready && !issue_valid_s) begin
            protocol_err_d = 1'b1;
        end else begin
            protocol_err_d = protocol_err_q;
        end
    end

    // Protocol error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            protocol_err_q <= 1'b0;
        end else begin
            protocol_err_q <= protocol_err_d;
        end
    end

    assign protocol_err = protocol_err_q;
`else
    assign protocol_err = 1'b0;
`endif

    assign off_ready      = off_ready_s;
    assign off_done       = off_done_s;
    assign off_accepted   = off_done_s && accept_q;
    assign issue_valid    = issue_valid_s;
    assign issue_instr    = instr_q;
    assign issue_id       = id_q;
    assign issue_rs       = rs_q;
    assign issue_rs_valid = {X_NUM_RS{1'b1}};
    assign issue_mode     = 2'b11;
    assign commit_valid   = commit_valid_s;
    assign commit_id      = id_q;
    assign commit_kill    = commit_valid_s && kill_q;
    assign result_ready   = result_ready_s;
    assign rf_we          = rf_we_q && !rst;
    assign rf_waddr       = rf_waddr_q;
    assign rf_wdata       = rf_wdata_q;
    assign exc_valid      = exc_valid_q && !rst;
    assign exc_code       = exc_code_q;
    assign outstanding    = outstanding_q;

endmodule

// File: doc/xif_host_offload.md
# xif_host_offload

Host-CPU-side initiator for the CORE-V-XIF issue, commit and result channels. It takes one instruction at a time from the core pipeline, issues it to the coprocessor (rvfpm), and commits or kills each accepted instruction. It tracks outstanding transaction IDs and writes returned results into the integer register file. It sits between the core decode stage and the coprocessor-side XIF ports; the memory channels are out of scope.

## Interface
Parameters:
- XLEN, 32, integer register width
- X_NUM_RS, 3, source operands forwarded per issue
- X_ID_WIDTH, 4, transaction ID width; the ID space is 2^X_ID_WIDTH
- X_RFR_WIDTH, 32, width of each source operand
- MAX_OUTSTANDING, 4, maximum accepted-but-unfinished instructions; 1..2^X_ID_WIDTH

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- off_valid  in  1  core offers an instruction
- off_ready  out  1  block accepts the core offer
- off_instr  in  32  instruction word
- off_rs  in  X_NUM_RS*X_RFR_WIDTH  source operands; rs[0] in the LSBs
- off_kill  in  1  kill decision; sampled with off_instr
- off_done  out  1  one-cycle pulse when the issue outcome is known
- off_accepted  out  1  valid with off_done; 0 means rejected (illegal instruction)
- issue_valid  out  1  XIF issue valid
- issue_ready  in  1  XIF issue ready
- issue_instr  out  32  issue_req.instr
- issue_id  out  X_ID_WIDTH  issue_req.id
- issue_rs  out  X_NUM_RS*X_RFR_WIDTH  issue_req.rs
- issue_rs_valid  out  X_NUM_RS  constant all-ones
- issue_mode  out  2  constant 2'b11 (machine mode)
- issue_accept  in  1  issue_resp.accept
- issue_writeback  in  1  issue_resp.writeback
- commit_valid  out  1  XIF commit valid
- commit_id  out  X_ID_WIDTH  commit.id
- commit_kill  out  1  commit.commit_kill
- result_valid  in  1  XIF result valid
- result_ready  out  1  XIF result ready
- result_id  in  X_ID_WIDTH  result.id
- result_data  in  XLEN  result.data
- result_rd  in  5  result.rd
- result_we  in  1  result.we
- result_exc  in  1  result.exc
- result_exccode  in  6  result.exccode
- rf_we  out  1  integer register file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  XLEN  write data
- exc_valid  out  1  one-cycle pulse on a result exception
- exc_code  out  6  exception code; valid with exc_valid
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  count of pending IDs
- protocol_err  out  1  sticky error flag

## Operation
- Issue FSM states: IDLE, ISSUE, COMMIT.
- IDLE:
  - off_ready = 1 iff pending[next_id]==0 and outstanding<MAX_OUTSTANDING.
  - On off_valid&&off_ready, register instr, rs and kill, drive issue_id=next_id, then go to ISSUE.
- ISSUE:
  - issue_valid=1; all issue outputs stay stable until issue_ready.
  - On issue_ready with issue_accept=1: set pending[id], set wb_exp[id]=issue_writeback, increment next_id (mod 2^X_ID_WIDTH), go to COMMIT.
  - On issue_ready with issue_accept=0: go to COMMIT without setting pending, and suppress commit_valid.
- COMMIT (one cycle):
  - off_done=1 and off_accepted=latched accept.
  - If accepted: commit_valid=1, commit_id=issue_id, commit_kill=latched kill.
  - If killed: clear pending[id] in this cycle (no result follows).
  - Go to IDLE.
- Result channel:
  - result_ready=1 whenever not in reset.
  - On handshake, clear pending[result_id].
  - If result_we && wb_exp[result_id], write rf_waddr=result_rd, rf_wdata=result_data; writes to rd=0 are suppressed.
  - If result_exc, pulse exc_valid with exc_code=result_exccode; rf_we=0 for that result.
- outstanding = popcount(pending). It may rise by 1 and fall by up to 2 in one cycle; all set/clear events on distinct IDs apply together.
- A result for the ID being set in the same cycle cannot occur, because allocation requires pending clear in the previous cycle.

## Timing
- Reset values: FSM in IDLE; next_id=0; pending=0; wb_exp=0; protocol_err=0. All valid, pulse and enable outputs are 0. Data outputs are 0; result_ready=0 during rst.
- Core handshake to issue_valid: 1 cycle.
- Issue handshake to commit_valid/off_done: 1 cycle.
- Minimum cost per instruction: 3 cycles.
- Result handshake to rf_we/exc_valid: 1 cycle, registered. Back-to-back results produce back-to-back writes.
- rst mid-transaction: everything aborts in the same cycle, with no commit emitted and no further rf writes.

## Configuration
- XIF_HOST_PROTOCOL_CHECK_EN defined: protocol_err sets, and stays set until rst, on any of:
  - a result for a non-pending ID;
  - result_we=1 when wb_exp=0;
  - issue_ready while issue_valid=0.
- Offending results are still consumed (result_ready unaffected) but never write the register file.
- Undefined: the checker logic is not compiled and protocol_err is tied to 0. The write-suppression gating still uses pending and wb_exp.

## Test plan
- Accepted, writeback: issue instr 0x00000053 with accept=1, writeback=1, then result id 0, rd=5, data=0x3F800000. Expect commit_valid with id 0, kill=0; rf_we with x5=0x3F800000 one cycle after the result; outstanding returns 1→0.
- Rejected: accept=0. Expect off_done with off_accepted=0, no commit_valid, outstanding stays 0, next_id stays 0.
- Killed: off_kill=1 and accepted. Expect commit_kill=1 with id 0, outstanding 1→0 in the commit cycle, next issue uses id 1.
- Full: MAX_OUTSTANDING=4 with no results. Expect off_ready=0 after 4 accepts; a result for id 2 reopens off_ready one cycle later.
- ID wrap: 17 sequential accept+result pairs. Expect the 17th issue_id=0; a stall is observed if id 0 is still pending.
- Check enabled: a result for id 7 while pending=0. Expect protocol_err=1 sticky, rf_we=0; rst clears it.
